// File: rtl/frame_capture_ctrl.sv
// frame_capture_ctrl
// Arms on a start request, captures exactly one video frame of packed
// binary pixel words into an image memory, then freezes the image so the
// shape analyser and the overlay can read it through a round-robin port.
//
// Read handshake: a requester raises rd_req[n] with rd_addr<n> and holds
// both stable until the cycle in which rd_gnt[n] is high (combinational,
// one cycle). The granted address is registered onto mem_rdaddress at the
// end of the grant cycle, and rd_valid[n] is high exactly two cycles after
// rd_gnt[n], the cycle in which the memory q belongs to that requester.
module frame_capture_ctrl #(
    parameter int WIDTH  = 640,
    parameter int HEIGHT = 480,
    parameter int AW     = 16
) (
    input  logic          VGA_CLK,
    input  logic          reset_n,
    input  logic          iVGA_VS,
    input  logic          start,
    input  logic          pix_wr_en,
    input  logic [AW-1:0] pix_wr_addr,
    input  logic [1:0]    rd_req,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    output logic [1:0]    rd_gnt,
    output logic [1:0]    rd_valid,
    output logic          mem_wren,
    output logic [AW-1:0] mem_wraddress,
    output logic [AW-1:0] mem_rdaddress,
    output logic [1:0]    state,
    output logic          frame_done,
    output logic          addr_err,
    output logic [AW-1:0] words_written
);

    // Number of words in one frame; addresses at or above this are invalid.
    localparam int unsigned FRAME_WORDS = WIDTH * HEIGHT / 8;
    localparam logic [AW:0] LIMIT       = FRAME_WORDS[AW:0];

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ARM     = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_FROZEN  = 2'd3
    } state_t;

    state_t        r_state;
    state_t        w_next;

    logic          r_vs_q;
    logic          w_vs_fall;
    logic          w_enter_arm;
    logic          w_end_capture;
    logic          w_addr_ok;
    logic          w_wr_take;
    logic          w_wr_bad;

    logic          r_mem_wren;
    logic [AW-1:0] r_mem_wraddress;
    logic [AW-1:0] r_words;
    logic          r_addr_err;
    logic          r_frame_done;

    logic          w_rd_open;
    logic [1:0]    w_gnt;
    logic [AW-1:0] w_gnt_addr;
    logic          r_last;      // 1: bit 1 was granted most recently
    logic [1:0]    r_gnt_d1;
    logic [1:0]    r_valid;
    logic [AW-1:0] r_mem_rdaddress;

    assign w_vs_fall     = r_vs_q & ~iVGA_VS;
    assign w_enter_arm   = (w_next == ST_ARM) && (r_state != ST_ARM);
    assign w_end_capture = (r_state == ST_CAPTURE) && (w_next == ST_FROZEN);
    assign w_addr_ok     = ({1'b0, pix_wr_addr} < LIMIT);
    assign w_wr_take     = (r_state == ST_CAPTURE) && pix_wr_en && w_addr_ok;
    assign w_wr_bad      = (r_state == ST_CAPTURE) && pix_wr_en && !w_addr_ok;

    // Registered copy of vertical sync for edge detection.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_vs_q <= 1'b1;
        end else begin
            r_vs_q <= iVGA_VS;
        end
    end

    // FSM state register.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next state: start only matters when idle or frozen.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:    if (start)     w_next = ST_ARM;
            ST_ARM:     if (w_vs_fall) w_next = ST_CAPTURE;
            ST_CAPTURE: if (w_vs_fall) w_next = ST_FROZEN;
            ST_FROZEN:  if (start)     w_next = ST_ARM;
            default:                   w_next = ST_IDLE;
        endcase
    end

    // Memory write port: one-cycle registered pass-through of valid writes.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_mem_wren      <= 1'b0;
            r_mem_wraddress <= '0;
        end else begin
            r_mem_wren <= w_wr_take;
            if (w_wr_take) begin
                r_mem_wraddress <= pix_wr_addr;
            end
        end
    end

    // Write statistics: saturating word count and sticky address error.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_words    <= '0;
            r_addr_err <= 1'b0;
        end else if (w_enter_arm) begin
            r_words    <= '0;
            r_addr_err <= 1'b0;
        end else begin
            if (r_mem_wren && (r_words != {AW{1'b1}})) begin
                r_words <= r_words + AW'(1);
            end
            if (w_wr_bad) begin
                r_addr_err <= 1'b1;
            end
        end
    end

    // Frame-done pulse in the first FROZEN cycle.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_end_capture;
        end
    end

    // Read arbiter: grants only while the image is stable, round-robin on conflict.
    assign w_rd_open = reset_n && ((r_state == ST_IDLE) || (r_state == ST_FROZEN));

    always_comb begin
        w_gnt = 2'b00;
        if (w_rd_open) begin
            case (rd_req)
                2'b01:   w_gnt = 2'b01;
                2'b10:   w_gnt = 2'b10;
                2'b11:   w_gnt = r_last ? 2'b01 : 2'b10;
                default: w_gnt = 2'b00;
            endcase
        end
    end

    assign w_gnt_addr = w_gnt[1] ? rd_addr1 : rd_addr0;

    // Read pipeline: pointer, read address and the two-cycle valid delay.
    // Valids keep flowing regardless of state so in-flight reads complete.
    always_ff @(posedge VGA_CLK or negedge reset_n) begin
        if (!reset_n) begin
            r_last          <= 1'b1;
            r_gnt_d1        <= 2'b00;
            r_valid         <= 2'b00;
            r_mem_rdaddress <= '0;
        end else begin
            r_gnt_d1 <= w_gnt;
            r_valid  <= r_gnt_d1;
            if (w_gnt != 2'b00) begin
                r_last          <= w_gnt[1];
                r_mem_rdaddress <= w_gnt_addr;
            end
        end
    end

    assign rd_gnt        = w_gnt;
    assign rd_valid      = r_valid;
    assign mem_wren      = r_mem_wren;
    assign mem_wraddress = r_mem_wraddress;
    assign mem_rdaddress = r_mem_rdaddress;
    assign state         = r_state;
    assign frame_done    = r_frame_done;
    assign addr_err      = r_addr_err;
    assign words_written = r_words;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed testbench for frame_capture_ctrl with default geometry
// (640x480 -> 38400 words per frame).
module tb_frame_capture_ctrl;

    localparam int AW    = 16;
    localparam int WORDS = 38400;

    logic          VGA_CLK;
    logic          reset_n;
    logic          iVGA_VS;
    logic          start;
    logic          pix_wr_en;
    logic [AW-1:0] pix_wr_addr;
    logic [1:0]    rd_req;
    logic [AW-1:0] rd_addr0;
    logic [AW-1:0] rd_addr1;
    logic [1:0]    rd_gnt;
    logic [1:0]    rd_valid;
    logic          mem_wren;
    logic [AW-1:0] mem_wraddress;
    logic [AW-1:0] mem_rdaddress;
    logic [1:0]    state;
    logic          frame_done;
    logic          addr_err;
    logic [AW-1:0] words_written;

    int n_checks = 0;
    int n_fail   = 0;

    frame_capture_ctrl dut (
        .VGA_CLK       (VGA_CLK),
        .reset_n       (reset_n),
        .iVGA_VS       (iVGA_VS),
        .start         (start),
        .pix_wr_en     (pix_wr_en),
        .pix_wr_addr   (pix_wr_addr),
        .rd_req        (rd_req),
        .rd_addr0      (rd_addr0),
        .rd_addr1      (rd_addr1),
        .rd_gnt        (rd_gnt),
        .rd_valid      (rd_valid),
        .mem_wren      (mem_wren),
        .mem_wraddress (mem_wraddress),
        .mem_rdaddress (mem_rdaddress),
        .state         (state),
        .frame_done    (frame_done),
        .addr_err      (addr_err),
        .words_written (words_written)
    );

    // Clock
    initial VGA_CLK = 1'b0;
    always #5 VGA_CLK = ~VGA_CLK;

    // Advance one clock; leaves time 1 unit after the rising edge.
    task automatic step();
        @(posedge VGA_CLK);
        #1;
    endtask

    // One vertical-sync falling edge (VS low for one cycle, then high).
    task automatic vs_pulse();
        iVGA_VS = 1'b0;
        step();
        iVGA_VS = 1'b1;
    endtask

    task automatic test_reset();
        reset_n     = 1'b0;
        iVGA_VS     = 1'b1;
        start       = 1'b0;
        pix_wr_en   = 1'b0;
        pix_wr_addr = '0;
        rd_req      = 2'b00;
        rd_addr0    = '0;
        rd_addr1    = '0;
        step();
        step();
        n_checks++;
        if (state !== 2'd0 || mem_wren !== 1'b0 || frame_done !== 1'b0 ||
            addr_err !== 1'b0 || rd_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_ctrl: state=%0d wren=%b done=%b err=%b valid=%b, expected 0 0 0 0 00",
                     state, mem_wren, frame_done, addr_err, rd_valid);
        end
        n_checks++;
        if (words_written !== 16'd0 || mem_wraddress !== 16'd0 || mem_rdaddress !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_data: words=%0d wa=%0d ra=%0d, expected all 0",
                     words_written, mem_wraddress, mem_rdaddress);
        end
        reset_n = 1'b1;
        step();
    endtask

    task automatic test_capture_frame();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (state !== 2'd1) begin
            n_fail++;
            $display("FAIL arm_state: got %0d expected 1", state);
        end
        vs_pulse();
        n_checks++;
        if (state !== 2'd2) begin
            n_fail++;
            $display("FAIL capture_state: got %0d expected 2", state);
        end
        for (int i = 0; i < WORDS; i++) begin
            pix_wr_en   = 1'b1;
            pix_wr_addr = AW'(i);
            step();
            if (i == 0 || i == WORDS - 1) begin
                n_checks++;
                if (mem_wren !== 1'b1 || mem_wraddress !== AW'(i)) begin
                    n_fail++;
                    $display("FAIL capture_write: wren=%b addr=%0d expected 1 %0d",
                             mem_wren, mem_wraddress, i);
                end
            end
        end
        pix_wr_en = 1'b0;
        step();
        n_checks++;
        if (words_written !== 16'd38400 || mem_wren !== 1'b0 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_count: words=%0d wren=%b done=%b expected 38400 0 0",
                     words_written, mem_wren, frame_done);
        end
        vs_pulse();
        n_checks++;
        if (state !== 2'd3 || frame_done !== 1'b1) begin
            n_fail++;
            $display("FAIL frozen_entry: state=%0d done=%b expected 3 1", state, frame_done);
        end
        step();
        n_checks++;
        if (frame_done !== 1'b0 || state !== 2'd3 || words_written !== 16'd38400) begin
            n_fail++;
            $display("FAIL frame_done_pulse: done=%b state=%0d words=%0d expected 0 3 38400",
                     frame_done, state, words_written);
        end
    endtask

    // Both requesters held for four cycles in FROZEN with a fresh pointer.
    task automatic test_rr_frozen();
        logic [1:0] pat [4];
        pat[0] = 2'b01;
        pat[1] = 2'b10;
        pat[2] = 2'b01;
        pat[3] = 2'b10;
        for (int c = 0; c < 6; c++) begin
            rd_req   = (c < 4) ? 2'b11 : 2'b00;
            rd_addr0 = AW'(16'h0100 + c);
            rd_addr1 = AW'(16'h0200 + c);
            #1;
            n_checks++;
            if (rd_gnt !== ((c < 4) ? pat[c] : 2'b00)) begin
                n_fail++;
                $display("FAIL rr_gnt c=%0d: got %b expected %b", c, rd_gnt,
                         (c < 4) ? pat[c] : 2'b00);
            end
            n_checks++;
            if (rd_valid !== ((c >= 2) ? pat[c-2] : 2'b00)) begin
                n_fail++;
                $display("FAIL rr_valid c=%0d: got %b expected %b", c, rd_valid,
                         (c >= 2) ? pat[c-2] : 2'b00);
            end
            step();
            if (c < 4) begin
                n_checks++;
                if (mem_rdaddress !== (pat[c][1] ? AW'(16'h0200 + c) : AW'(16'h0100 + c))) begin
                    n_fail++;
                    $display("FAIL rr_rdaddr c=%0d: got %h expected %h", c, mem_rdaddress,
                             pat[c][1] ? AW'(16'h0200 + c) : AW'(16'h0100 + c));
                end
            end
        end
    endtask

    task automatic test_addr_err();
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (state !== 2'd1 || words_written !== 16'd0 || addr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL rearm_clear: state=%0d words=%0d err=%b expected 1 0 0",
                     state, words_written, addr_err);
        end
        vs_pulse();
        pix_wr_en   = 1'b1;
        pix_wr_addr = 16'd38400;
        step();
        n_checks++;
        if (mem_wren !== 1'b0 || addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_oob: wren=%b err=%b expected 0 1", mem_wren, addr_err);
        end
        pix_wr_addr = 16'd38399;
        step();
        pix_wr_en = 1'b0;
        n_checks++;
        if (mem_wren !== 1'b1 || mem_wraddress !== 16'd38399 || addr_err !== 1'b1) begin
            n_fail++;
            $display("FAIL addr_last: wren=%b addr=%0d err=%b expected 1 38399 1",
                     mem_wren, mem_wraddress, addr_err);
        end
        step();
        vs_pulse();
        n_checks++;
        if (state !== 2'd3 || addr_err !== 1'b1 || words_written !== 16'd1) begin
            n_fail++;
            $display("FAIL err_sticky: state=%0d err=%b words=%0d expected 3 1 1",
                     state, addr_err, words_written);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        n_checks++;
        if (addr_err !== 1'b0 || words_written !== 16'd0) begin
            n_fail++;
            $display("FAIL err_clear: err=%b words=%0d expected 0 0", addr_err, words_written);
        end
    endtask

    // Strobes in ARM and FROZEN, read request pending through CAPTURE.
    task automatic test_idle_states_and_rd_capture();
        pix_wr_en   = 1'b1;
        pix_wr_addr = 16'd5;
        step();
        step();
        n_checks++;
        if (mem_wren !== 1'b0 || words_written !== 16'd0 || state !== 2'd1) begin
            n_fail++;
            $display("FAIL arm_strobe: wren=%b words=%0d state=%0d expected 0 0 1",
                     mem_wren, words_written, state);
        end
        vs_pulse();
        for (int i = 0; i < 3; i++) begin
            pix_wr_addr = AW'(100 + i);
            step();
        end
        pix_wr_en = 1'b0;
        rd_req    = 2'b01;
        rd_addr0  = 16'h0ABC;
        #1;
        n_checks++;
        if (rd_gnt !== 2'b00 || state !== 2'd2) begin
            n_fail++;
            $display("FAIL capture_no_gnt: gnt=%b state=%0d expected 00 2", rd_gnt, state);
        end
        step();
        vs_pulse();
        #1;
        n_checks++;
        if (state !== 2'd3 || rd_gnt !== 2'b01 || words_written !== 16'd3) begin
            n_fail++;
            $display("FAIL frozen_first_gnt: state=%0d gnt=%b words=%0d expected 3 01 3",
                     state, rd_gnt, words_written);
        end
        step();
        rd_req = 2'b00;
        n_checks++;
        if (mem_rdaddress !== 16'h0ABC) begin
            n_fail++;
            $display("FAIL frozen_rdaddr: got %h expected 0abc", mem_rdaddress);
        end
        pix_wr_en   = 1'b1;
        pix_wr_addr = 16'd7;
        step();
        n_checks++;
        if (rd_valid !== 2'b01) begin
            n_fail++;
            $display("FAIL frozen_valid: got %b expected 01", rd_valid);
        end
        step();
        pix_wr_en = 1'b0;
        n_checks++;
        if (mem_wren !== 1'b0 || words_written !== 16'd3) begin
            n_fail++;
            $display("FAIL frozen_strobe: wren=%b words=%0d expected 0 3", mem_wren, words_written);
        end
    endtask

    task automatic test_async_reset();
        start = 1'b1;
        step();
        start = 1'b0;
        vs_pulse();
        pix_wr_en   = 1'b1;
        pix_wr_addr = 16'd42;
        step();
        step();
        n_checks++;
        if (mem_wren !== 1'b1 || state !== 2'd2 || words_written !== 16'd1) begin
            n_fail++;
            $display("FAIL pre_reset: wren=%b state=%0d words=%0d expected 1 2 1",
                     mem_wren, state, words_written);
        end
        reset_n = 1'b0;
        rd_req  = 2'b01;
        #1;
        n_checks++;
        if (mem_wren !== 1'b0 || state !== 2'd0 || words_written !== 16'd0 ||
            mem_wraddress !== 16'd0 || mem_rdaddress !== 16'd0 || rd_gnt !== 2'b00) begin
            n_fail++;
            $display("FAIL async_reset: wren=%b state=%0d words=%0d wa=%0d ra=%0d gnt=%b expected all 0",
                     mem_wren, state, words_written, mem_wraddress, mem_rdaddress, rd_gnt);
        end
        rd_req = 2'b00;
        step();
        reset_n = 1'b1;
        step();
        step();
        n_checks++;
        if (state !== 2'd0 || mem_wren !== 1'b0 || words_written !== 16'd0 || rd_valid !== 2'b00) begin
            n_fail++;
            $display("FAIL post_reset: state=%0d wren=%b words=%0d valid=%b expected 0 0 0 00",
                     state, mem_wren, words_written, rd_valid);
        end
        pix_wr_en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_capture_frame();
        test_rr_frozen();
        test_addr_err();
        test_idle_states_and_rd_capture();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
